// File: rtl/bip_checker.sv
// Receive-side per-lane BIP3 checker for a 100GBASE-R PCS lane.
// Optional BIP7 format check: define BIP_CHECK_BIP7_EN.
module bip_checker #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int NB_BIP          = 8,
  parameter int NB_ERR_COUNT    = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [LEN_CODED_BLOCK-1:0] i_data,
  input  logic                    i_am_valid,
  input  logic                    i_clear_count,
  output logic [NB_BIP-1:0]       o_bip_calc,
  output logic [NB_BIP-1:0]       o_bip_rcv,
  output logic                    o_bip_valid,
  output logic                    o_bip_error,
  output logic [NB_ERR_COUNT-1:0] o_error_count,
  output logic                    o_am_format_error
);

  typedef enum logic {
    WAIT_AM = 1'b0,
    RUN     = 1'b1
  } state_t;

  localparam int LB = LEN_CODED_BLOCK;
  localparam logic [NB_ERR_COUNT-1:0] CNT_MAX = '1;
  localparam logic [NB_ERR_COUNT-1:0] CNT_ONE = NB_ERR_COUNT'(1);

  state_t state;
  state_t next_state;

  logic [NB_BIP-1:0] acc;
  logic [NB_BIP-1:0] acc_next;
  logic [NB_BIP-1:0] blk_bip;
  logic [NB_BIP-1:0] bip3;
  logic              cmp;
  logic              mismatch;

  // Per-block BIP: tx bit n lives at i_data[LB-1-n]
  always_comb begin
    blk_bip = '0;
    for (int j = 0; j < NB_BIP; j++) begin
      for (int k = 0; k < 8; k++) begin
        blk_bip[j] = blk_bip[j] ^ i_data[LB-1-(j+2+8*k)];
      end
    end
    blk_bip[3] = blk_bip[3] ^ i_data[LB-1];
    blk_bip[4] = blk_bip[4] ^ i_data[LB-2];
  end

  // BIP3 field carried in tx bits 26..33 of an AM
  always_comb begin
    bip3 = '0;
    for (int m = 0; m < NB_BIP; m++) begin
      bip3[m] = i_data[LB-1-(26+m)];
    end
  end

  // Next-state, accumulator update and compare strobe
  always_comb begin
    next_state = state;
    acc_next   = acc;
    cmp        = 1'b0;
    unique case (state)
      WAIT_AM: begin
        if (i_enable && i_am_valid) begin
          acc_next   = blk_bip;
          next_state = RUN;
        end
      end
      RUN: begin
        if (i_enable) begin
          if (i_am_valid) begin
            cmp      = 1'b1;
            acc_next = blk_bip;
          end else begin
            acc_next = acc ^ blk_bip;
          end
        end
      end
      default: next_state = WAIT_AM;
    endcase
  end

  assign mismatch = cmp && (acc != bip3);

  // State, accumulator, compare results and error counter
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state         <= WAIT_AM;
      acc           <= '0;
      o_bip_calc    <= '0;
      o_bip_rcv     <= '0;
      o_bip_valid   <= 1'b0;
      o_bip_error   <= 1'b0;
      o_error_count <= '0;
    end else begin
      state       <= next_state;
      acc         <= acc_next;
      o_bip_valid <= cmp;
      o_bip_error <= mismatch;
      if (cmp) begin
        o_bip_calc <= acc;
        o_bip_rcv  <= bip3;
      end
      if (i_clear_count) begin
        o_error_count <= mismatch ? CNT_ONE : '0;
      end else if (mismatch && o_error_count != CNT_MAX) begin
        o_error_count <= o_error_count + CNT_ONE;
      end
    end
  end

`ifdef BIP_CHECK_BIP7_EN
  logic [NB_BIP-1:0] bip7;

  // BIP7 field carried in tx bits 58..65 of an AM
  always_comb begin
    bip7 = '0;
    for (int m = 0; m < NB_BIP; m++) begin
      bip7[m] = i_data[LB-1-(58+m)];
    end
  end

  // BIP7 must be the complement of BIP3 on every AM
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_am_format_error <= 1'b0;
    end else begin
      o_am_format_error <= i_enable && i_am_valid
                           && (bip7 != ~bip3);
    end
  end
`else
  assign o_am_format_error = 1'b0;
`endif

endmodule

// File: tb/tb_bip_checker.sv
// Self-checking bench for bip_checker.
// Scoreboard of expected AM compares plus directed scenarios.
module tb_bip_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [65:0] data = '0;
  logic        am = 1'b0;
  logic        clr = 1'b0;

  logic [7:0]  calc, rcv, calc2, rcv2;
  logic        valid, err, valid2, err2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic        fmt, fmt2;

  always #5 clk = ~clk;

  bip_checker u_dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .i_data(data), .i_am_valid(am), .i_clear_count(clr),
    .o_bip_calc(calc), .o_bip_rcv(rcv),
    .o_bip_valid(valid), .o_bip_error(err),
    .o_error_count(cnt), .o_am_format_error(fmt)
  );

  bip_checker #(.NB_ERR_COUNT(2)) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .i_data(data), .i_am_valid(am), .i_clear_count(clr),
    .o_bip_calc(calc2), .o_bip_rcv(rcv2),
    .o_bip_valid(valid2), .o_bip_error(err2),
    .o_error_count(cnt2), .o_am_format_error(fmt2)
  );

`ifdef BIP_CHECK_BIP7_EN
  localparam bit BIP7_EN = 1'b1;
`else
  localparam bit BIP7_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  calc;
    logic [7:0]  rcv;
    logic        err;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  bit          m_run;
  logic [7:0]  m_acc;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  function automatic logic [7:0] bip_of(input logic [65:0] d);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 8; k++)
        b[j] = b[j] ^ d[65-(j+2+8*k)];
    b[3] = b[3] ^ d[65];
    b[4] = b[4] ^ d[64];
    return b;
  endfunction

  function automatic logic [7:0] f3(input logic [65:0] d);
    logic [7:0] f;
    for (int m = 0; m < 8; m++) f[m] = d[65-(26+m)];
    return f;
  endfunction

  function automatic logic [65:0] mk_am(
    input logic [7:0] b3, input logic [7:0] b7);
    logic [65:0] d;
    d = '0;
    d[64] = 1'b1;
    for (int m = 0; m < 8; m++) begin
      d[65-(26+m)] = b3[m];
      d[65-(58+m)] = b7[m];
    end
    return d;
  endfunction

  function automatic logic [65:0] rnd66();
    logic [65:0] r;
    r = {2'($urandom()), $urandom(), $urandom()};
    return r;
  endfunction

  localparam logic [65:0] ZBLK = 66'd1 << 64;

  task automatic drive(input logic r, input logic e,
                       input logic a, input logic c,
                       input logic [65:0] d);
    bit v, x;
    exp_t t;
    if (!r) begin
      m_run = 0; m_acc = '0; m_cnt = '0; m_cnt2 = '0;
    end else begin
      v = e && a && m_run;
      x = v && (m_acc != f3(d));
      if (c) begin
        m_cnt  = x ? 16'd1 : 16'd0;
        m_cnt2 = x ? 2'd1 : 2'd0;
      end else if (x) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
      if (v) begin
        t.calc = m_acc; t.rcv = f3(d); t.err = x;
        t.cnt = m_cnt; t.cnt2 = m_cnt2;
        sb.push_back(t);
      end
      if (e) begin
        if (a) begin
          m_acc = bip_of(d); m_run = 1;
        end else if (m_run) begin
          m_acc = m_acc ^ bip_of(d);
        end
      end
    end
    rst = r; en = e; am = a; clr = c; data = d;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one entry per compare pulse
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_valid got=1 want=0");
        end else begin
          e = sb.pop_front();
          if ({calc, rcv, err, cnt, cnt2} !==
              {e.calc, e.rcv, e.err, e.cnt, e.cnt2}) begin
            n_bad++;
            $display("FAIL sb_compare got=%h/%h/%b/%0d/%0d want=%h/%h/%b/%0d/%0d",
              calc, rcv, err, cnt, cnt2,
              e.calc, e.rcv, e.err, e.cnt, e.cnt2);
          end
        end
      end else begin
        n_cmp++;
        if (err !== 1'b0) begin
          n_bad++;
          $display("FAIL err_without_valid got=%b want=0", err);
        end
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1'($urandom()), 0, rnd66());
      mon_en = 1'b1;
      n_cmp++;
      if ({calc, rcv, valid, err, cnt, fmt, cnt2} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs got=%h/%h/%b/%b/%0d/%b want=0",
          calc, rcv, valid, err, cnt, fmt);
      end
    end
    drive(1, 1, 1, 0, mk_am(8'h33, 8'hCC));
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL first_am_valid got=%b want=0", valid);
    end
  endtask

  task automatic run_seq(input logic [7:0] b3, input logic [7:0] b7);
    drive(0, 0, 0, 0, ZBLK);
    drive(1, 1, 1, 0, mk_am(8'h10, 8'hEF));
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL seed_valid got=%b want=0", valid);
    end
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, ZBLK);
    drive(1, 1, 1, 0, mk_am(b3, b7));
  endtask

  task automatic test_match();
    run_seq(8'hFF, 8'h00);
    n_cmp++;
    if ({valid, err, calc, cnt} !== {1'b1, 1'b0, 8'hFF, 16'd0}) begin
      n_bad++;
      $display("FAIL match got=%b/%b/%h/%0d want=1/0/ff/0",
        valid, err, calc, cnt);
    end
  endtask

  task automatic test_mismatch();
    run_seq(8'hFE, 8'h01);
    n_cmp++;
    if ({valid, err, rcv, calc, cnt} !==
        {1'b1, 1'b1, 8'hFE, 8'hFF, 16'd1}) begin
      n_bad++;
      $display("FAIL mismatch got=%b/%b/%h/%h/%0d want=1/1/fe/ff/1",
        valid, err, rcv, calc, cnt);
    end
    drive(1, 0, 0, 0, ZBLK);
    n_cmp++;
    if ({valid, err} !== 2'b00) begin
      n_bad++;
      $display("FAIL pulse_width got=%b%b want=00", valid, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1, 1, 1, 0, mk_am(8'h00, 8'hFF));
    drive(1, 0, 0, 1, ZBLK);
    n_cmp++;
    if ({cnt, cnt2} !== 18'd0) begin
      n_bad++;
      $display("FAIL clear_alone got=%0d/%0d want=0/0", cnt, cnt2);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, mk_am(8'h00, 8'hFF));
      n_cmp++;
      if ({err, cnt, cnt2} !== {1'b1, 16'(i + 1), sat[i]}) begin
        n_bad++;
        $display("FAIL saturate[%0d] got=%b/%0d/%0d want=1/%0d/%0d",
          i, err, cnt, cnt2, i + 1, sat[i]);
      end
    end
  endtask

  task automatic test_clear_with_error();
    drive(1, 1, 1, 1, mk_am(8'h00, 8'hFF));
    n_cmp++;
    if ({err, cnt, cnt2} !== {1'b1, 16'd1, 2'd1}) begin
      n_bad++;
      $display("FAIL clear_with_err got=%b/%0d/%0d want=1/1/1",
        err, cnt, cnt2);
    end
    drive(1, 0, 0, 1, ZBLK);
    n_cmp++;
    if ({cnt, cnt2} !== 18'd0) begin
      n_bad++;
      $display("FAIL clear_after got=%0d/%0d want=0/0", cnt, cnt2);
    end
  endtask

  task automatic test_bip7();
    drive(0, 0, 0, 0, ZBLK);
    drive(1, 1, 1, 0, mk_am(8'h5A, 8'h5A));
    n_cmp++;
    if ({fmt, valid, cnt} !== {BIP7_EN, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL bip7_flag got=%b/%b/%0d want=%b/0/0",
        fmt, valid, cnt, BIP7_EN);
    end
    drive(1, 1, 1, 0, mk_am(8'h5A, 8'hA5));
    n_cmp++;
    if (fmt !== 1'b0) begin
      n_bad++;
      $display("FAIL bip7_clean got=%b want=0", fmt);
    end
  endtask

  task automatic test_random();
    drive(0, 0, 0, 0, ZBLK);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0),
            rnd66());
    end
    drive(1, 0, 0, 0, ZBLK);
    drive(1, 0, 0, 0, ZBLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_back_to_back();
    test_clear_with_error();
    test_bip7();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
